wb_stage: RTL

- Writeback stage of the RISC-V core; sits directly upstream of the register file write port (waddr/we/wdata).
- Registers MEM-stage results and formats load data (byte/half select, sign/zero extension).
- Merges results from a long-latency unit (divider) through a small FIFO and arbitrates them onto the regfile's single write port.

---
 rtl/wb_stage_pkg.sv | 47 ++++
 rtl/wb_stage_div_fifo.sv | 94 +++++++++
 rtl/wb_stage.sv | 128 ++++++++++++
 3 files changed

// File: rtl/wb_stage_pkg.sv
//============================================================================
// Module      : wb_stage_pkg
// Description : Shared bus widths, load funct3 codes and load-data formatter
//               for the writeback stage.
// Revision    : 1.0 - initial release
//============================================================================
`ifndef WB_STAGE_DEFINES
`define WB_STAGE_DEFINES
`define REG_BUS      31:0
`define REG_ADDR_BUS 4:0
`endif

`default_nettype none

package wb_stage_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // Selects the addressed byte/half of the RAM word and extends it.
    function automatic logic [`REG_BUS] format_load(
        input logic [2:0]      ld_type,
        input logic [1:0]      addr_lo,
        input logic [`REG_BUS] word
    );
        logic [7:0]      sel_b;
        logic [15:0]     sel_h;
        logic [`REG_BUS] res;
        sel_b = word[{addr_lo, 3'b000} +: 8];
        sel_h = addr_lo[1] ? word[31:16] : word[15:0];
        case (ld_type)
            LB:      res = {{24{sel_b[7]}}, sel_b};
            LH:      res = {{16{sel_h[15]}}, sel_h};
            LW:      res = word;
            LBU:     res = {24'd0, sel_b};
            LHU:     res = {16'd0, sel_h};
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_stage_div_fifo.sv
//============================================================================
// Module      : wb_div_fifo
// Description : Synchronous FIFO for divider results; drops x0 writes and,
//               with WB_HAZARD_CHK_EN, reports source-register matches.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module wb_div_fifo
    import wb_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [`REG_ADDR_BUS] push_addr,
    input  logic [`REG_BUS]      push_data,
    input  logic                 pop,
    output logic [`REG_ADDR_BUS] head_addr,
    output logic [`REG_BUS]      head_data,
`ifdef WB_HAZARD_CHK_EN
    input  logic [`REG_ADDR_BUS] match_addr_a,
    input  logic [`REG_ADDR_BUS] match_addr_b,
    output logic                 match_a,
    output logic                 match_b,
`endif
    output logic                 empty,
    output logic                 full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [`REG_ADDR_BUS] r_addr [DEPTH];
    logic [`REG_BUS]      r_data [DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic                 w_store;
    logic                 w_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CW'(DEPTH));
    assign head_addr = r_addr[r_rd_ptr];
    assign head_data = r_data[r_rd_ptr];

    // x0 results are accepted from the divider but never occupy a slot.
    assign w_store = push & ~full & (push_addr != '0);
    assign w_pop   = pop & ~empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_addr[r_wr_ptr] <= push_addr;
            r_data[r_wr_ptr] <= push_data;
        end
    end

`ifdef WB_HAZARD_CHK_EN
    logic [DEPTH-1:0] w_hit_a;
    logic [DEPTH-1:0] w_hit_b;

    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        logic [PW-1:0] w_offset;
        logic          w_live;
        assign w_offset   = PW'(i) - r_rd_ptr;
        assign w_live     = ({1'b0, w_offset} < r_count);
        assign w_hit_a[i] = w_live & (r_addr[i] == match_addr_a);
        assign w_hit_b[i] = w_live & (r_addr[i] == match_addr_b);
    end

    assign match_a = |w_hit_a;
    assign match_b = |w_hit_b;
`endif

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
//============================================================================
// Module      : wb_stage
// Description : Writeback stage: load formatting plus divider-result merge
//               onto the single regfile write port. Option: WB_HAZARD_CHK_EN.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DIV_FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_rd_we_i,
    input  logic [`REG_ADDR_BUS] mem_rd_addr_i,
    input  logic [`REG_BUS]      mem_rd_data_i,
    input  logic                 mem_ld_en_i,
    input  logic [2:0]           mem_ld_type_i,
    input  logic [1:0]           mem_ld_addr_lo_i,
    input  logic                 mem_flush_i,
    input  logic [`REG_BUS]      dram_rdata_i,
    input  logic                 div_valid_i,
    output logic                 div_ready_o,
    input  logic [`REG_ADDR_BUS] div_rd_addr_i,
    input  logic [`REG_BUS]      div_data_i,
`ifdef WB_HAZARD_CHK_EN
    input  logic [`REG_ADDR_BUS] id_rs1_addr_i,
    input  logic [`REG_ADDR_BUS] id_rs2_addr_i,
    output logic                 wb_hazard_o,
`endif
    output logic                 wb_stall_o,
    output logic                 wb_rd_we_o,
    output logic [`REG_ADDR_BUS] wb_rd_addr_o,
    output logic [`REG_BUS]      wb_rd_data_o
);

    logic                 r_valid;
    logic [`REG_ADDR_BUS] r_addr;
    logic [`REG_BUS]      r_data;
    logic                 r_ld_en;
    logic [2:0]           r_ld_type;
    logic [1:0]           r_ld_lo;

    logic                 w_fifo_empty;
    logic                 w_fifo_full;
    logic                 w_fifo_pop;
    logic [`REG_ADDR_BUS] w_head_addr;
    logic [`REG_BUS]      w_head_data;
    logic [`REG_BUS]      w_slot_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_ld_en   <= 1'b0;
            r_ld_type <= '0;
            r_ld_lo   <= '0;
        end else begin
            r_valid   <= mem_rd_we_i & ~mem_flush_i & (mem_rd_addr_i != '0);
            r_addr    <= mem_rd_addr_i;
            r_data    <= mem_rd_data_i;
            r_ld_en   <= mem_ld_en_i;
            r_ld_type <= mem_ld_type_i;
            r_ld_lo   <= mem_ld_addr_lo_i;
        end
    end

    assign w_slot_data = r_ld_en ? format_load(r_ld_type, r_ld_lo, dram_rdata_i) : r_data;

    // The pipeline slot always wins; the FIFO only uses bubbles.
    always_comb begin
        wb_rd_we_o   = 1'b0;
        wb_rd_addr_o = '0;
        wb_rd_data_o = '0;
        w_fifo_pop   = 1'b0;
        if (r_valid) begin
            wb_rd_we_o   = 1'b1;
            wb_rd_addr_o = r_addr;
            wb_rd_data_o = w_slot_data;
        end else if (!w_fifo_empty) begin
            wb_rd_we_o   = 1'b1;
            wb_rd_addr_o = w_head_addr;
            wb_rd_data_o = w_head_data;
            w_fifo_pop   = 1'b1;
        end
    end

    assign div_ready_o = ~w_fifo_full;
    assign wb_stall_o  = w_fifo_full;

`ifdef WB_HAZARD_CHK_EN
    logic w_match_rs1;
    logic w_match_rs2;

    assign wb_hazard_o =
        ((id_rs1_addr_i != '0) &
         (w_match_rs1 | (div_valid_i & (div_rd_addr_i == id_rs1_addr_i)))) |
        ((id_rs2_addr_i != '0) &
         (w_match_rs2 | (div_valid_i & (div_rd_addr_i == id_rs2_addr_i))));
`endif

    wb_div_fifo #(
        .DEPTH        (DIV_FIFO_DEPTH)
    ) u_div_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (div_valid_i & div_ready_o),
        .push_addr    (div_rd_addr_i),
        .push_data    (div_data_i),
        .pop          (w_fifo_pop),
        .head_addr    (w_head_addr),
        .head_data    (w_head_data),
`ifdef WB_HAZARD_CHK_EN
        .match_addr_a (id_rs1_addr_i),
        .match_addr_b (id_rs2_addr_i),
        .match_a      (w_match_rs1),
        .match_b      (w_match_rs2),
`endif
        .empty        (w_fifo_empty),
        .full         (w_fifo_full)
    );

endmodule

`default_nettype wire
